// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-master sequencer for the memory-mapped UART core.
//
// Polls the UART status register and drains received bytes into a small RX
// FIFO presented as a valid/ready stream. Shares the single UART transmitter
// between two byte requesters using round-robin arbitration.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   tx0_* / tx1_*           requester byte streams (data, valid in; ready pulse out)
//   rx_data/rx_valid/rx_level  head, non-empty flag and occupancy of the RX FIFO
//   rx_ready                consumer pops the head when rx_valid & rx_ready
//   uart_addr/din/lane/wr/valid  UART register access (addr bit 2: 1 = status)
//   uart_dout               UART registered read data, valid one cycle after addr
//   last_grant              index of the most recently granted TX requester
module uart_ctrl #(
    parameter int RX_DEPTH = 4,
    parameter int SETTLE   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                tx0_data,
    input  logic                      tx0_valid,
    output logic                      tx0_ready,
    input  logic [7:0]                tx1_data,
    input  logic                      tx1_valid,
    output logic                      tx1_ready,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic [2:0]                uart_addr,
    output logic [31:0]               uart_din,
    input  logic [31:0]               uart_dout,
    output logic [3:0]                uart_lane,
    output logic                      uart_wr,
    output logic                      uart_valid,
    output logic                      last_grant
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_POLL,
        S_POLL_WAIT,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_SETTLE
    } state_t;

    state_t state, next_state;

    logic [7:0]    mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          fifo_full, push, pop;
    logic          tx_idle, rx_avail;
    logic          grant;
    logic [CW-1:0] settle_cnt;
    logic          unused_dout;

    assign tx_idle     = uart_dout[14];
    assign rx_avail    = uart_dout[8];
    assign unused_dout = ^{uart_dout[31:15], uart_dout[13:9]};

    assign fifo_full = (count == LW'(RX_DEPTH));
    // The UART is never read while the FIFO is full, so the guard only
    // protects against an impossible overflow.
    assign push      = (state == S_RD_WAIT) && !fifo_full;
    assign pop       = rx_valid && rx_ready;

    assign rx_valid = (count != '0);
    assign rx_level = count;
    assign rx_data  = mem[rd_ptr];

    // Round-robin: with both requesters pending, the one not granted last wins.
    always_comb begin
        if (tx0_valid && tx1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = ~tx0_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_POLL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_POLL:      next_state = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (rx_avail && !fifo_full) begin
                    next_state = S_RD;
                end else if (tx_idle && (tx0_valid || tx1_valid)) begin
                    next_state = S_WR;
                end else begin
                    next_state = S_POLL;
                end
            end
            S_RD:        next_state = S_RD_WAIT;
            S_RD_WAIT:   next_state = S_POLL;
            S_WR:        next_state = (SETTLE == 0) ? S_POLL : S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == CW'(SETTLE - 1)) begin
                    next_state = S_POLL;
                end
            end
            default:     next_state = S_POLL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
        end else if (state == S_SETTLE) begin
            settle_cnt <= settle_cnt + CW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Bus outputs are registered from the next state so that they line up
    // with the state the controller is actually in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_addr  <= 3'b100;
            uart_din   <= '0;
            uart_lane  <= 4'b0001;
            uart_wr    <= 1'b0;
            uart_valid <= 1'b0;
            tx0_ready  <= 1'b0;
            tx1_ready  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            uart_addr  <= (next_state == S_POLL || next_state == S_POLL_WAIT) ? 3'b100 : 3'b000;
            uart_lane  <= 4'b0001;
            uart_wr    <= (next_state == S_WR);
            uart_valid <= (next_state == S_RD) || (next_state == S_WR);
            tx0_ready  <= (next_state == S_WR) && !grant;
            tx1_ready  <= (next_state == S_WR) && grant;
            if (next_state == S_WR) begin
                uart_din   <= {24'd0, grant ? tx1_data : tx0_data};
                last_grant <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; reset discards contents by clearing pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_dout[7:0];
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl.
//
// Contains a registered UART model (status/data registers, RX byte queue),
// a transaction-level model of the controller (FIFO contents, arbitration,
// bus spacing and RX priority) checked every cycle, and directed phases with
// literal expectations.
module tb_uart_ctrl;

    localparam int RX_DEPTH = 4;
    localparam int SETTLE   = 2;
    localparam int LW       = $clog2(RX_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    tx0_data, tx1_data;
    logic          tx0_valid, tx1_valid;
    logic          tx0_ready, tx1_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [LW-1:0] rx_level;
    logic [2:0]    uart_addr;
    logic [31:0]   uart_din;
    logic [31:0]   uart_dout = '0;
    logic [3:0]    uart_lane;
    logic          uart_wr;
    logic          uart_valid;
    logic          last_grant;

    uart_ctrl #(.RX_DEPTH(RX_DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_ready(tx0_ready),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
        .uart_addr(uart_addr), .uart_din(uart_din), .uart_dout(uart_dout),
        .uart_lane(uart_lane), .uart_wr(uart_wr), .uart_valid(uart_valid),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // UART model: registered status/data, RX bytes queued by the bench.
    logic       tx_idle_st;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin : uart_model
        logic [31:0] w;
        w = '0;
        if (uart_valid && !uart_wr) begin
            if (rx_q.size() != 0) w[7:0] = rx_q.pop_front();
            uart_dout <= w;
        end else if (uart_addr[2]) begin
            w[14] = tx_idle_st;
            w[8]  = (rx_q.size() != 0);
            uart_dout <= w;
        end
    end

    // Controller model state.
    logic [7:0]  m_fifo[$];
    logic        m_last = 1'b1;
    logic        m_pend = 1'b0;
    logic [7:0]  m_pend_byte = '0;
    logic        m_push;
    logic        m_g;
    logic        prev_v0 = 0, prev_v1 = 0;
    logic [7:0]  prev_d0 = 0, prev_d1 = 0;
    logic [31:0] prev_dout = '0;
    int          prev_size = 0;
    int          cyc = 0;
    int          last_rd = -100, last_wr = -100;
    int          read_count = 0;
    logic [7:0]  wr_log[$];
    logic        gr_log[$];
    logic [7:0]  ev_log[$];
    int          ev_cyc[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            m_fifo.delete();
            m_last = 1'b1; m_pend = 1'b0;
            prev_v0 = 0; prev_v1 = 0; prev_dout = '0; prev_size = 0;
            last_rd = -100; last_wr = -100;
        end else begin
            cyc++;
            checkOutput("rx_valid", rx_valid, m_fifo.size() != 0);
            checkOutput("rx_level", rx_level, m_fifo.size());
            if (m_fifo.size() != 0) checkOutput("rx_data", rx_data, m_fifo[0]);
            checkOutput("uart_lane", uart_lane, 4'b0001);
            checkOutput("wr_without_valid", uart_wr && !uart_valid, 0);
            if (uart_valid) begin
                checkOutput("access_addr", uart_addr, 0);
                checkOutput("gap_after_rd", (cyc - last_rd) >= 4, 1);
                checkOutput("gap_after_wr", (cyc - last_wr) >= SETTLE + 3, 1);
            end
            if (uart_valid && uart_wr) begin
                m_g = (prev_v0 && prev_v1) ? !m_last : !prev_v0;
                checkOutput("wr_had_request", prev_v0 | prev_v1, 1);
                checkOutput("wr_tx_idle", prev_dout[14], 1);
                checkOutput("wr_rx_priority", prev_dout[8] && prev_size < RX_DEPTH, 0);
                checkOutput("uart_din", uart_din, {24'd0, m_g ? prev_d1 : prev_d0});
                checkOutput("tx0_ready", tx0_ready, !m_g);
                checkOutput("tx1_ready", tx1_ready, m_g);
                checkOutput("last_grant_wr", last_grant, m_g);
                m_last = m_g;
                wr_log.push_back(uart_din[7:0]);
                gr_log.push_back(last_grant);
                ev_log.push_back(8'h57);
                ev_cyc.push_back(cyc);
                last_wr = cyc;
            end else begin
                checkOutput("tx0_ready_idle", tx0_ready, 0);
                checkOutput("tx1_ready_idle", tx1_ready, 0);
                checkOutput("last_grant", last_grant, m_last);
            end
            if (uart_valid && !uart_wr) begin
                checkOutput("rd_rx_avail", prev_dout[8] && prev_size < RX_DEPTH, 1);
                checkOutput("rd_uart_has_byte", rx_q.size() != 0, 1);
                m_pend_byte = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
                read_count++;
                ev_log.push_back(8'h52);
                ev_cyc.push_back(cyc);
                last_rd = cyc;
            end
            // Advance the model to the state after the coming edge.
            prev_size = m_fifo.size();
            m_push = m_pend;
            m_pend = uart_valid && !uart_wr;
            if (m_fifo.size() != 0 && rx_ready) void'(m_fifo.pop_front());
            if (m_push) m_fifo.push_back(m_pend_byte);
            prev_v0 = tx0_valid; prev_v1 = tx1_valid;
            prev_d0 = tx0_data;  prev_d1 = tx1_data;
            prev_dout = uart_dout;
        end
    end

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1,
                                 input logic idle, input logic rdy);
        @(posedge clk);
        #1;
        tx0_valid = v0; tx0_data = d0;
        tx1_valid = v1; tx1_data = d1;
        tx_idle_st = idle; rx_ready = rdy;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_uart_addr"}, uart_addr, 3'b100);
        checkOutput({tag, "_uart_din"}, uart_din, 0);
        checkOutput({tag, "_uart_lane"}, uart_lane, 4'b0001);
        checkOutput({tag, "_uart_wr"}, uart_wr, 0);
        checkOutput({tag, "_uart_valid"}, uart_valid, 0);
        checkOutput({tag, "_tx0_ready"}, tx0_ready, 0);
        checkOutput({tag, "_tx1_ready"}, tx1_ready, 0);
        checkOutput({tag, "_rx_valid"}, rx_valid, 0);
        checkOutput({tag, "_rx_level"}, rx_level, 0);
        checkOutput({tag, "_last_grant"}, last_grant, 1);
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checkResetValues("rst");
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    logic found;

    // which: 0 = bus write cycle, 1 = rx_valid
    task automatic waitFor(input int which, input int limit, input string name);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            found = (which == 0) ? (uart_valid && uart_wr) : rx_valid;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout_%s: no event in %0d cycles, expected one", name, limit);
        end
        #1;
    endtask

    int         base;
    logic [7:0] popped[$];

    initial begin
        reset_n = 1'b0;
        tx0_valid = 0; tx0_data = 0; tx1_valid = 0; tx1_data = 0;
        tx_idle_st = 1'b1; rx_ready = 1'b0;
        #13 checkResetValues("por");
        @(negedge clk);
        #2 reset_n = 1'b1;

        $display("[TB] idle polling");
        repeat (8) begin
            @(negedge clk);
            checkOutput("idle_addr", uart_addr, 3'b100);
            checkOutput("idle_valid", uart_valid, 0);
        end
        checkOutput("idle_no_events", ev_log.size(), 0);

        $display("[TB] single tx0 write");
        applyStimulus(1, 8'h41, 0, 8'h00, 1, 0);
        waitFor(0, 20, "tx0_write");
        checkOutput("b_din", uart_din, 32'h41);
        checkOutput("b_wr", uart_wr, 1);
        checkOutput("b_tx0_ready", tx0_ready, 1);
        base = wr_log.size();
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        repeat (SETTLE + 2) begin
            @(negedge clk);
            checkOutput("b_no_rewrite", uart_valid, 0);
        end
        repeat (6) @(negedge clk);
        checkOutput("b_one_write", wr_log.size(), base);

        $display("[TB] round-robin alternation");
        applyReset();
        base = wr_log.size();
        applyStimulus(1, 8'hA0, 1, 8'hB1, 1, 0);
        for (int i = 0; i < 4; i++) waitFor(0, 20, "rr_write");
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        repeat (4) @(negedge clk);
        if (wr_log.size() >= base + 4) begin
            checkOutput("c_wr0", wr_log[base], 8'hA0);
            checkOutput("c_wr1", wr_log[base+1], 8'hB1);
            checkOutput("c_wr2", wr_log[base+2], 8'hA0);
            checkOutput("c_wr3", wr_log[base+3], 8'hB1);
            checkOutput("c_gr0", gr_log[base], 0);
            checkOutput("c_gr1", gr_log[base+1], 1);
            checkOutput("c_gr2", gr_log[base+2], 0);
        end else begin
            checkOutput("c_write_count", wr_log.size() - base, 4);
        end

        $display("[TB] single rx byte");
        rx_q.push_back(8'h5A);
        waitFor(1, 20, "rx_5a");
        checkOutput("d_rx_valid", rx_valid, 1);
        checkOutput("d_rx_data", rx_data, 8'h5A);
        checkOutput("d_rx_level", rx_level, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        @(negedge clk);
        checkOutput("d_rx_level_popped", rx_level, 0);

        $display("[TB] fifo full backpressure");
        base = read_count;
        for (int i = 0; i < 6; i++) rx_q.push_back(8'(8'h10 + i));
        repeat (40) @(negedge clk);
        checkOutput("e_reads_until_full", read_count - base, 4);
        checkOutput("e_rx_level_full", rx_level, 4);
        checkOutput("e_uart_pending", rx_q.size(), 2);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        popped.delete();
        for (int i = 0; i < 60 && popped.size() < 6; i++) begin
            @(negedge clk);
            if (rx_valid && rx_ready) popped.push_back(rx_data);
        end
        checkOutput("e_pop_count", popped.size(), 6);
        for (int i = 0; i < popped.size(); i++) checkOutput("e_pop_order", popped[i], 8'h10 + i);
        checkOutput("e_reads_total", read_count - base, 6);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        $display("[TB] rx priority and reset during write");
        applyStimulus(1, 8'h33, 0, 8'h00, 0, 0);
        repeat (6) @(negedge clk);
        base = ev_log.size();
        checkOutput("f_no_write_busy", uart_valid, 0);
        @(posedge clk);
        #1;
        rx_q.push_back(8'h77);
        tx_idle_st = 1'b1;
        waitFor(0, 30, "f_write");
        if (ev_log.size() >= base + 2) begin
            checkOutput("f_first_rd", ev_log[base], 8'h52);
            checkOutput("f_then_wr", ev_log[base+1], 8'h57);
            checkOutput("f_next_poll", ev_cyc[base+1] - ev_cyc[base], 4);
        end else begin
            checkOutput("f_event_count", ev_log.size() - base, 2);
        end
        checkOutput("f_rx_level_before", rx_level, 1);
        #1 reset_n = 1'b0;
        #1 checkResetValues("wr_rst");
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        waitFor(0, 30, "f_rewrite");
        checkOutput("f_rewrite_din", uart_din, 32'h33);
        checkOutput("f_rewrite_ready", tx0_ready, 1);
        checkOutput("f_rewrite_grant", last_grant, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
